ro_measure_sequencer: RTL and testbench
=======================================

# ro_measure_sequencer

Measurement sequencer for the instrumented ring oscillator. On a start request it enables the oscillator and discards edges for a fixed settle time. It then counts synchronized rising edges of the oscillator's divided output over a programmable window of system-clock cycles, latches the result and disables the oscillator. It sits between the top-level pin wrapper (start/abort/window select from `ui_in`, result bytes to `uo_out`) and the oscillator/divider macro.

## Interface
- `CNT_W`, 16: width of edge accumulator and result, valid range 8..24.
- `SETTLE_CYC`, 16: cycles the oscillator runs before counting starts, must be ≥ 1.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  level, sampled only in IDLE; high starts a measurement.
- `abort`  in  1  level; cancels a measurement in SETTLE or MEASURE.
- `win_sel`  in  3  window = 2^(win_sel+8) cycles (256..32768); latched on start.
- `ro_div`  in  1  divided oscillator output, asynchronous to `clk`.
- `ro_en`  out  1  registered oscillator enable.
- `busy`  out  1  high in SETTLE, MEASURE, LATCH.
- `done`  out  1  sticky; set on result latch, cleared when next start is accepted.
- `overflow`  out  1  result saturated; updated on latch.
- `count`  out  CNT_W  last latched result.
- `byte_sel`  in  2  selects result byte for `data_out`.
- `data_out`  out  8  `count[8*byte_sel +: 8]`, combinational; bits above CNT_W read 0.

## Operation
- Synchronizer: `ro_div` passes through flops s1, s2, s3. `edge = s2 & ~s3`. These flops run in all states and reset to 0.
- States: IDLE, SETTLE, MEASURE, LATCH.
- IDLE → SETTLE when `start` is high and `abort` is low.
  - Latch `win_sel`, clear the accumulator, clear `done` and `overflow`.
  - `ro_en` becomes 1.
- SETTLE lasts exactly SETTLE_CYC cycles. Edges are ignored. Then go to MEASURE.
- MEASURE lasts exactly 2^(latched win_sel+8) cycles.
  - Every cycle in MEASURE with `edge` = 1 increments the accumulator.
  - The accumulator saturates at all-ones and sets an internal sat flag.
  - Then go to LATCH.
- LATCH (1 cycle): `count` ← accumulator, `overflow` ← sat, `done` ← 1, `ro_en` ← 0. Then go to IDLE.
- `abort` high in SETTLE or MEASURE: go to IDLE next cycle with `ro_en` = 0. `count`, `overflow` and `done` stay 0/unchanged, since `done` was already cleared at start.
- `abort` in LATCH or IDLE: ignored. An `abort` and `start` both high in IDLE: no start.
- `start` while busy: ignored. Holding `start` high retriggers a new measurement on the cycle after LATCH returns to IDLE.
- Window counter width: 15 bits, compared against the latched terminal value. It wraps to 0 on entering MEASURE.
- Input constraint: `ro_div` high and low phases must each be ≥ 2 `clk` periods. Faster inputs undercount; no error flag is raised.

## Timing
- Reset (`rst_n` low at a rising edge): state = IDLE, `ro_en` = 0, `busy` = 0, `done` = 0, `overflow` = 0, `count` = 0, accumulator = 0, sync flops = 0, `data_out` = 0.
  - Reset mid-measurement behaves the same and takes priority over all inputs.
- `start` sampled at edge T0: `busy` = `ro_en` = 1 after T0.
  - First counted cycle is T0 + SETTLE_CYC.
  - `done` = 1 and `ro_en` = 0 after edge T0 + SETTLE_CYC + 2^(w+8) + 1.
- Edge latency: an `ro_div` rise produces `edge` 2–3 cycles later. Rises within the last 2 cycles of MEASURE are not counted.
- `count`/`overflow` change only in LATCH; they stay stable while the next measurement runs.

## Test plan
- Reset then idle 10 cycles → all outputs 0, `ro_en` = 0.
- SETTLE_CYC = 16, `win_sel` = 0, `ro_div` period 8 clk (4 high/4 low) running from reset → `count` = 32 (±1 allowed for phase), `done` = 1 exactly 273 cycles after start, `ro_en` low the same cycle, `data_out` with `byte_sel` = 0 reads 0x20 (±1).
- CNT_W = 8, `win_sel` = 2, `ro_div` period 4 → `count` = 255, `overflow` = 1. A following run with period 16 and `win_sel` = 0 → `overflow` = 0, `count` = 16 (±1).
- Assert `abort` 100 cycles into MEASURE → IDLE next cycle, `ro_en` = 0, `done` = 0, `count` = 0. Assert `start` again → a normal full result.
- Pulse `start` during MEASURE, and assert `rst_n` = 0 for 1 cycle mid-SETTLE of a second run → extra start has no effect, first result unchanged. After reset all outputs are 0 and the state is IDLE.
- Hold `start` high continuously with `win_sel` toggling during MEASURE → back-to-back measurements one IDLE cycle apart, each using the `win_sel` value at its own start.

Source files
------------

// File: rtl/ro_measure_sequencer.sv
// Ring-oscillator measurement sequencer: enable, settle, count synchronized
// divided-oscillator rises over a 2^(win_sel+8) cycle window, then latch.
module ro_measure_sequencer #(
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       win_sel,
  input  logic             ro_div,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [CNT_W-1:0] count,
  input  logic [1:0]       byte_sel,
  output logic [7:0]       data_out
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, LATCH} state_t;

  state_t            state, state_nxt;
  logic              s1, s2, s3, rise;
  logic              go;
  logic [2:0]        win_q;
  logic [14:0]       win_cnt, win_last;
  logic [SW-1:0]     settle_cnt;
  logic [CNT_W-1:0]  acc;
  logic              sat;
  logic [31:0]       cnt_pad;

  assign rise     = s2 & ~s3;
  assign win_last = 15'((32'd1 << (32'(win_q) + 32'd8)) - 32'd1);
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    case (state)
      IDLE: if (start && !abort) begin
        state_nxt = SETTLE;
        go        = 1'b1;
      end
      SETTLE: begin
        if (abort)                           state_nxt = IDLE;
        else if (settle_cnt == SETTLE_LAST)  state_nxt = MEASURE;
      end
      MEASURE: begin
        if (abort)                   state_nxt = IDLE;
        else if (win_cnt == win_last) state_nxt = LATCH;
      end
      LATCH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      ro_en      <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      count      <= '0;
      acc        <= '0;
      sat        <= 1'b0;
      win_q      <= '0;
      win_cnt    <= '0;
      settle_cnt <= '0;
    end else begin
      s1 <= ro_div;
      s2 <= s1;
      s3 <= s2;
      case (state)
        IDLE: if (go) begin
          win_q      <= win_sel;
          acc        <= '0;
          sat        <= 1'b0;
          done       <= 1'b0;
          overflow   <= 1'b0;
          ro_en      <= 1'b1;
          settle_cnt <= '0;
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + SW'(1);
          win_cnt    <= '0;
          if (abort) ro_en <= 1'b0;
        end
        MEASURE: begin
          win_cnt <= win_cnt + 15'd1;
          // saturate rather than wrap so a too-fast oscillator is flagged
          if (rise) begin
            if (&acc) sat <= 1'b1;
            else      acc <= acc + CNT_W'(1);
          end
          if (abort) ro_en <= 1'b0;
        end
        LATCH: begin
          count    <= acc;
          overflow <= sat;
          done     <= 1'b1;
          ro_en    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign cnt_pad  = 32'(count);
  assign data_out = cnt_pad[{byte_sel, 3'b000} +: 8];

endmodule

// File: tb/tb_ro_measure_sequencer.sv
// Bench for ro_measure_sequencer: random-phase ro_div, counts predicted from
// the recorded input history and the documented edge latency.
module tb_ro_measure_sequencer;
  localparam int S = 16;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, ro_div = 1'b0;
  logic [2:0]  win_sel = 3'd0;
  logic [1:0]  byte_sel = 2'd0;

  logic        ro_en, busy, done, overflow;
  logic [15:0] count;
  logic [7:0]  data_out;
  logic        ro_en8, busy8, done8, overflow8;
  logic [7:0]  count8;
  logic [7:0]  data_out8;

  ro_measure_sequencer #(.CNT_W(16), .SETTLE_CYC(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .win_sel(win_sel),
    .ro_div(ro_div), .ro_en(ro_en), .busy(busy), .done(done), .overflow(overflow),
    .count(count), .byte_sel(byte_sel), .data_out(data_out));

  ro_measure_sequencer #(.CNT_W(8), .SETTLE_CYC(S)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .win_sel(win_sel),
    .ro_div(ro_div), .ro_en(ro_en8), .busy(busy8), .done(done8), .overflow(overflow8),
    .count(count8), .byte_sel(byte_sel), .data_out(data_out8));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ro_left = 0;
  int ro_lo = 4, ro_hi = 4;
  bit hist[$];

  // ro_div as seen by the first synchronizer flop at every rising edge
  always @(posedge clk) hist.push_back(rst_n ? ro_div : 1'b0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (ro_left == 0) begin
      ro_div  = ~ro_div;
      ro_left = $urandom_range(ro_hi, ro_lo);
    end
    ro_left--;
    @(posedge clk);
    #1;
  endtask

  // A rise sampled at edge j is seen as edge during the cycle after edge j+1
  // and counted if that cycle lies in the window [t0+S, t0+S+W-1].
  function automatic int rises(input int t0, input int w);
    int n = 0;
    for (int k = t0 + S; k < t0 + S + (256 << w); k++)
      if (k >= 2 && hist[k-1] && !hist[k-2]) n++;
    return n;
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, ":busy"}, busy, 0);   check({tag, ":ro_en"}, ro_en, 0);
    check({tag, ":done"}, done, 0);   check({tag, ":ovf"}, overflow, 0);
    check({tag, ":count"}, count, 0); check({tag, ":data"}, data_out, 0);
    check({tag, ":busy8"}, busy8, 0); check({tag, ":count8"}, count8, 0);
    check({tag, ":ro_en8"}, ro_en8, 0);
  endtask

  task automatic measure(input int w, input int w_mid, input bit hold,
                         input int pulse_at, input string tag);
    int t0, win, n;
    logic [31:0] c16, c8;
    win = 256 << w;
    win_sel = w[2:0];
    start = 1'b1;
    tick();
    t0 = hist.size() - 1;
    start = hold;
    check({tag, ":busy0"}, busy, 1);
    check({tag, ":ro_en0"}, ro_en, 1);
    check({tag, ":done0"}, done, 0);
    for (int i = 1; i <= S + win; i++) begin
      win_sel = (i >= S + 8) ? w_mid[2:0] : w[2:0];
      start   = hold || (i == pulse_at);
      tick();
    end
    start = hold;
    check({tag, ":done_early"}, done, 0);
    check({tag, ":busy_latch"}, busy, 1);
    tick();
    n   = rises(t0, w);
    c16 = (n > 65535) ? 32'd65535 : 32'(n);
    c8  = (n > 255) ? 32'd255 : 32'(n);
    check({tag, ":done"}, done, 1);
    check({tag, ":ro_en"}, ro_en, 0);
    check({tag, ":busy"}, busy, 0);
    check({tag, ":count"}, count, c16);
    check({tag, ":ovf"}, overflow, (n > 65535) ? 1 : 0);
    check({tag, ":done8"}, done8, 1);
    check({tag, ":count8"}, count8, c8);
    check({tag, ":ovf8"}, overflow8, (n > 255) ? 1 : 0);
    byte_sel = 2'd0; #1;
    check({tag, ":b0"}, data_out, c16[7:0]);
    check({tag, ":b0_8"}, data_out8, c8[7:0]);
    byte_sel = 2'd1; #1;
    check({tag, ":b1"}, data_out, c16[15:8]);
    check({tag, ":b1_8"}, data_out8, 0);
    byte_sel = 2'd2; #1;
    check({tag, ":b2"}, data_out, 0);
    byte_sel = 2'd0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check_idle_zero("reset");

    // period 8 running since reset, smallest window
    measure(0, 0, 0, -1, "A");
    check("A:range", (count >= 16'd31 && count <= 16'd33) ? 1 : 0, 1);

    // fast oscillator saturates the 8-bit instance, then a slow clean run
    ro_lo = 2; ro_hi = 2;
    measure(2, 2, 0, -1, "B2");
    measure(3, 3, 0, -1, "B3");
    check("B3:sat8", overflow8, 1);
    ro_lo = 8; ro_hi = 8;
    measure(0, 0, 0, -1, "B16");
    check("B16:range", (count8 >= 8'd15 && count8 <= 8'd17) ? 1 : 0, 1);

    // stray start pulse mid-measure, then reset during SETTLE of a second run
    ro_lo = 3; ro_hi = 3;
    measure(1, 1, 0, S + 50, "C");
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    check("C:settle_busy", busy, 1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check_idle_zero("C_rst");
    tick();
    check("C:idle_busy", busy, 0);
    check("C:idle_ro_en", ro_en, 0);

    // abort 100 cycles into MEASURE
    win_sel = 3'd0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (S + 100) tick();
    check("D:meas_busy", busy, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    check_idle_zero("D_abort");
    start = 1'b1; abort = 1'b1; tick();
    start = 1'b0; abort = 1'b0;
    check("D:start_abort", busy, 0);
    measure(0, 0, 0, -1, "D2");

    // start held high: back-to-back runs, each window from its own start
    measure(1, 0, 1, -1, "E1");
    measure(0, 2, 0, -1, "E2");

    for (int r = 0; r < 6; r++) begin
      int w;
      ro_lo = 2;
      ro_hi = $urandom_range(9, 2);
      w = $urandom_range(2, 0);
      measure(w, $urandom_range(7, 0), 0, -1, "R");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
